// File: rtl/jtgng_cen_frac.sv
// Fractional N/M clock-enable generator with power-of-two sub-enables.
// Ticks suppressed by wait_n are counted in lag and replayed on idle cycles.
module jtgng_cen_frac #(
  parameter int W    = 10,
  parameter int N    = 1,
  parameter int M    = 2,
  parameter int DIVS = 4,
  parameter int MW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wait_n,
  input  logic            sync,
  output logic [DIVS-1:0] cen,
  output logic [MW-1:0]   lag,
  output logic            ovf
);
  localparam int DW = (DIVS > 1) ? DIVS - 1 : 1;

  logic [W-1:0]    acc_q, acc_d;
  logic [W:0]      sum;
  logic            nat;
  logic            tick;
  logic [DW-1:0]   divcnt_q, divcnt_d;
  logic [MW-1:0]   lag_q, lag_d;
  logic            ovf_q, ovf_d;
  logic [DIVS-1:0] cen_q, cen_d;

  // One extra bit so acc+N never wraps before the compare against M.
  assign sum   = {1'b0, acc_q} + (W+1)'(N);
  assign nat   = sum >= (W+1)'(M);
  assign acc_d = nat ? W'(sum - (W+1)'(M)) : sum[W-1:0];

  always_comb begin
    tick  = 1'b0;
    lag_d = lag_q;
    ovf_d = ovf_q;
    if (!wait_n) begin
      if (nat) begin
        if (&lag_q) ovf_d = 1'b1;
        else        lag_d = lag_q + MW'(1);
      end
    end else if (nat) begin
      tick = 1'b1;
    end else if (lag_q != '0) begin
      tick  = 1'b1;
      lag_d = lag_q - MW'(1);
    end
  end

  assign divcnt_d = tick ? divcnt_q + DW'(1) : divcnt_q;
  assign cen_d[0] = tick;

  // Sub-enable i fires on every 2^i-th base tick, starting with the first.
  generate
    for (genvar gi = 1; gi < DIVS; gi++) begin : g_div
      assign cen_d[gi] = tick && (divcnt_q[gi-1:0] == '0);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      divcnt_q <= '0;
      lag_q    <= '0;
      ovf_q    <= 1'b0;
      cen_q    <= '0;
    end else if (sync) begin
      acc_q    <= '0;
      divcnt_q <= '0;
      lag_q    <= '0;
      ovf_q    <= 1'b0;
      cen_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      divcnt_q <= divcnt_d;
      lag_q    <= lag_d;
      ovf_q    <= ovf_d;
      cen_q    <= cen_d;
    end
  end

  assign cen = cen_q;
  assign lag = lag_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_jtgng_cen_frac.sv
// Bench for jtgng_cen_frac: three configurations share stimulus and are
// checked every cycle against an arithmetic tick-count model.
module tb_jtgng_cen_frac;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wait_n = 1'b1;
  logic       sync = 1'b0;
  logic [3:0] cen_a, cen_b;
  logic [1:0] cen_c;
  logic [3:0] lag_a, lag_b;
  logic [1:0] lag_c;
  logic       ovf_a, ovf_b, ovf_c;

  int n_chk = 0;
  int n_fail = 0;
  int pa, pb;

  // Model configuration: A = 1/4, B = 3/8, C = 1/2 with a 2-bit lag counter.
  int pn[3] = '{1, 3, 1};
  int pm[3] = '{4, 8, 2};
  int pd[3] = '{4, 4, 2};
  int plmax[3] = '{15, 15, 3};
  longint mk[3];
  int mt[3], ml[3], mo[3], mc[3];

  always #5 clk = ~clk;

  jtgng_cen_frac #(.W(10), .N(1), .M(4), .DIVS(4), .MW(4)) u_a (
    .clk(clk), .rst(rst), .wait_n(wait_n), .sync(sync),
    .cen(cen_a), .lag(lag_a), .ovf(ovf_a));
  jtgng_cen_frac #(.W(10), .N(3), .M(8), .DIVS(4), .MW(4)) u_b (
    .clk(clk), .rst(rst), .wait_n(wait_n), .sync(sync),
    .cen(cen_b), .lag(lag_b), .ovf(ovf_b));
  jtgng_cen_frac #(.W(10), .N(1), .M(2), .DIVS(2), .MW(2)) u_c (
    .clk(clk), .rst(rst), .wait_n(wait_n), .sync(sync),
    .cen(cen_c), .lag(lag_c), .ovf(ovf_c));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      mk[j] = 0; mt[j] = 0; ml[j] = 0; mo[j] = 0; mc[j] = 0;
    end
  endtask

  // Natural tick on edge k iff floor(k*N/M) advanced; ticks since resync
  // decide which sub-enables join a base pulse.
  task automatic model_edge();
    bit nat, t;
    for (int j = 0; j < 3; j++) begin
      if (rst || sync) begin
        mk[j] = 0; mt[j] = 0; ml[j] = 0; mo[j] = 0; mc[j] = 0;
      end else begin
        mk[j]++;
        nat = ((mk[j] * pn[j]) / pm[j]) != (((mk[j] - 1) * pn[j]) / pm[j]);
        t = 1'b0;
        if (!wait_n) begin
          if (nat) begin
            if (ml[j] == plmax[j]) mo[j] = 1;
            else ml[j]++;
          end
        end else if (nat) begin
          t = 1'b1;
        end else if (ml[j] > 0) begin
          t = 1'b1;
          ml[j]--;
        end
        mc[j] = 0;
        if (t) begin
          for (int i = 0; i < pd[j]; i++)
            if (mt[j] % (1 << i) == 0) mc[j] |= (1 << i);
          mt[j]++;
        end
      end
    end
  endtask

  task automatic cmp_all();
    chk("A.cen", int'(cen_a), mc[0]);
    chk("A.lag", int'(lag_a), ml[0]);
    chk("A.ovf", int'(ovf_a), mo[0]);
    chk("B.cen", int'(cen_b), mc[1]);
    chk("B.lag", int'(lag_b), ml[1]);
    chk("B.ovf", int'(ovf_b), mo[1]);
    chk("C.cen", int'(cen_c), mc[2]);
    chk("C.lag", int'(lag_c), ml[2]);
    chk("C.ovf", int'(ovf_c), mo[2]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
    pa += int'(cen_a[0]);
    pb += int'(cen_b[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sync = 1'b0;
    wait_n = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Free run: exact average rates.
    pa = 0; pb = 0;
    for (int e = 1; e <= 800; e++) step();
    chk("A.pulses800", pa, 200);
    chk("B.pulses800", pb, 300);
    $display("free-run: A %0d pulses, B %0d pulses", pa, pb);

    // Wait window on edges 5..16, then replay.
    do_reset();
    pa = 0;
    for (int e = 1; e <= 40; e++) begin
      wait_n = !(e >= 5 && e <= 16);
      step();
      if (e == 16) begin
        chk("A.lag_wait", int'(lag_a), 3);
        chk("C.lag_sat", int'(lag_c), 3);
        chk("C.ovf_set", int'(ovf_c), 1);
      end
      if (e >= 17 && e <= 20) chk("A.replay", int'(cen_a[0]), 1);
    end
    chk("A.pulses40", pa, 10);
    chk("A.lag_drained", int'(lag_a), 0);
    chk("C.ovf_sticky", int'(ovf_c), 1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("C.lag_sync", int'(lag_c), 0);
    chk("C.ovf_sync", int'(ovf_c), 0);
    $display("wait/replay: A %0d pulses by edge 40", pa);

    // Phase resync on edge 7.
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      sync = (e == 7);
      step();
      if (e == 7)  chk("B.cen_sync", int'(cen_b), 0);
      if (e == 8 || e == 9) chk("B.cen_gap", int'(cen_b), 0);
      if (e == 10) chk("B.cen_first", int'(cen_b), 15);
      if (e == 13) chk("B.cen_13", int'(cen_b[0]), 1);
      if (e == 15) chk("B.cen_15", int'(cen_b[0]), 1);
    end
    sync = 1'b0;
    $display("resync: done");

    // Asynchronous reset while a tick is out and ticks are owed.
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      wait_n = !(e >= 5 && e <= 15);
      step();
    end
    chk("A.cen_pre_rst", int'(cen_a[0]), 1);
    chk("A.lag_pre_rst", int'(lag_a), 2);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    cmp_all();
    chk("A.lag_async", int'(lag_a), 0);
    step();
    rst = 1'b0;
    for (int e = 1; e <= 40; e++) step();
    $display("async reset: done");

    // Random wait/sync traffic with occasional asynchronous reset.
    for (int e = 0; e < 3000; e++) begin
      wait_n = ($urandom % 4) != 0;
      sync = ($urandom % 64) == 0;
      if (($urandom % 500) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        cmp_all();
        step();
        rst = 1'b0;
      end
      step();
    end
    sync = 1'b0;
    $display("random: 3000 cycles done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
